// File: rtl/dram_strobe_responder.sv
`default_nettype none
// ============================================================================
// dram_strobe_responder
// 4164-style RAS/CAS/MA decode turning each CAS cycle into one req/ack
// transaction. Optional macro DRAM_REFRESH_EN: RAS-only refresh pulse/count.
// Rev 1.0
// ============================================================================
module dram_strobe_responder #(
  parameter int BANK_W = 3
) (
  input  logic               clk_16,
  input  logic               RESET_N,
  input  logic               RAS_N,
  input  logic               CAS_N,
  input  logic               MWE_N,
  input  logic [7:0]         MA,
  input  logic [BANK_W-1:0]  BANK,
  input  logic [7:0]         D_IN,
  output logic [7:0]         D_OUT,
  output logic               D_OE,
  output logic [15+BANK_W:0] mem_addr,
  output logic               mem_wr,
  output logic [7:0]         mem_wdata,
  output logic               mem_req,
  input  logic               mem_ack,
  input  logic [7:0]         mem_rdata,
  output logic               overrun,
  output logic               ref_pulse
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROW  = 2'd1,
    S_BUSY = 2'd2,
    S_DATA = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_ras_prev;
  logic              r_cas_prev;
  logic [7:0]        r_row;
  logic [BANK_W-1:0] r_bank;

  logic w_ras_fall, w_ras_rise, w_cas_fall, w_cas_rise;
  logic w_ld_row, w_ld_col, w_req_clr, w_rd_load, w_oe_clr, w_ovr_set;

  assign w_ras_fall = r_ras_prev & ~RAS_N;
  assign w_ras_rise = ~r_ras_prev & RAS_N;
  assign w_cas_fall = r_cas_prev & ~CAS_N;
  assign w_cas_rise = ~r_cas_prev & CAS_N;

  always_ff @(posedge clk_16 or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_ld_row  = 1'b0;
    w_ld_col  = 1'b0;
    w_req_clr = 1'b0;
    w_rd_load = 1'b0;
    w_oe_clr  = 1'b0;
    w_ovr_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A CAS fall here is CAS-before-RAS refresh and is ignored.
        if (w_ras_fall) begin
          w_ld_row = 1'b1;
          w_next   = S_ROW;
        end
      end
      S_ROW: begin
        if (w_ras_rise) begin
          w_next = S_IDLE;
        end else if (w_cas_fall) begin
          w_ld_col = 1'b1;
          w_next   = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_cas_fall) w_ovr_set = 1'b1;
        if (mem_ack) begin
          w_req_clr = 1'b1;
          if (!CAS_N) begin
            w_rd_load = ~mem_wr;
            w_next    = S_DATA;
          end else begin
            // CAS already gone: the data has nowhere to go.
            w_ovr_set = 1'b1;
            w_next    = RAS_N ? S_IDLE : S_ROW;
          end
        end
      end
      S_DATA: begin
        if (w_cas_rise) begin
          w_oe_clr = 1'b1;
          w_next   = RAS_N ? S_IDLE : S_ROW;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_16 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ras_prev <= 1'b1;
      r_cas_prev <= 1'b1;
      r_row      <= '0;
      r_bank     <= '0;
      mem_addr   <= '0;
      mem_wr     <= 1'b0;
      mem_wdata  <= '0;
      mem_req    <= 1'b0;
      D_OUT      <= '0;
      D_OE       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      r_ras_prev <= RAS_N;
      r_cas_prev <= CAS_N;
      if (w_ld_row) begin
        r_row  <= MA;
        r_bank <= BANK;
      end
      if (w_ld_col) begin
        mem_addr  <= {r_bank, r_row, MA};
        mem_wr    <= ~MWE_N;
        mem_wdata <= D_IN;
        mem_req   <= 1'b1;
      end
      if (w_req_clr) mem_req <= 1'b0;
      if (w_rd_load) begin
        D_OUT <= mem_rdata;
        D_OE  <= 1'b1;
      end
      if (w_oe_clr)  D_OE    <= 1'b0;
      if (w_ovr_set) overrun <= 1'b1;
    end
  end

`ifdef DRAM_REFRESH_EN
  logic        r_cas_seen;
  logic [15:0] ref_count;
  logic        w_ras_only;

  // Row closed without any CAS since it opened: RAS-only refresh.
  assign w_ras_only = (r_state == S_ROW) && w_ras_rise && !r_cas_seen && !w_cas_fall;

  always_ff @(posedge clk_16 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cas_seen <= 1'b0;
      ref_count  <= '0;
      ref_pulse  <= 1'b0;
    end else begin
      ref_pulse <= w_ras_only;
      if (w_ras_only) ref_count <= ref_count + 16'd1;
      if (w_ld_row)
        r_cas_seen <= 1'b0;
      else if (w_cas_fall && (r_state != S_IDLE))
        r_cas_seen <= 1'b1;
    end
  end
`else
  assign ref_pulse = 1'b0;
`endif

endmodule
`default_nettype wire
